// File: rtl/cg_vector_writeback_pkg.sv
// Shared sizing helpers and types for the CG vector write-back path.
package cg_vector_writeback_pkg;

  // Bank identifier; the write bank is always the opposite of the read bank.
  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  // Word width at the default configuration (8 units x 32 bits).
  localparam int unsigned DEFAULT_WORD_WIDTH = 8 * 32;

  // Number of words needed to hold one full solution vector.
  function automatic int unsigned calc_words(input int unsigned clusters,
                                             input int unsigned eqs_per_cluster,
                                             input int unsigned units);
    return (clusters * eqs_per_cluster + units - 1) / units;
  endfunction

  // Bits in one write/read word.
  function automatic int unsigned word_bits(input int unsigned units,
                                            input int unsigned elem_width);
    return units * elem_width;
  endfunction

  // Ceiling log2, never less than 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/cg_vector_bank.sv
// One vector bank: single synchronous write port and a registered read port,
// written so that it maps onto a block RAM.
import cg_vector_writeback_pkg::*;

module cg_vector_bank #(
  parameter int unsigned DEPTH  = 95,
  parameter int unsigned WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned IDX_W = clog2_min1(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // RAM write and registered read; out-of-range addresses are ignored here
  // and zeroed by the top level.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_A)) mem[waddr[IDX_W-1:0]] <= wdata;
    if (raddr < DEPTH_A) rdata_q <= mem[raddr[IDX_W-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cg_vector_writeback.sv
// Write-back end of the CG ALU result path: assembles result chunks into a
// full vector in a ping-pong bank pair and exposes the last committed vector.
import cg_vector_writeback_pkg::*;

module cg_vector_writeback #(
  parameter int unsigned number_of_clusters              = 40,
  parameter int unsigned number_of_equations_per_cluster = 19,
  parameter int unsigned element_width                   = 32,
  parameter int unsigned no_of_units                     = 8,
  parameter int unsigned memories_address_width          = 20
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   restart,
  input  logic                                   wr_we,
  input  logic [no_of_units*element_width-1:0]   wr_data,
  output logic [memories_address_width-1:0]      wr_count,
  input  logic [memories_address_width-1:0]      rd_address,
  output logic [no_of_units*element_width-1:0]   rd_data,
  output logic                                   read_bank,
  output logic                                   vector_done,
  output logic [31:0]                            vectors_committed,
  output logic                                   valid
);

  localparam int unsigned WORDS  = calc_words(number_of_clusters,
                                              number_of_equations_per_cluster,
                                              no_of_units);
  localparam int unsigned WORD_W = word_bits(no_of_units, element_width);
  localparam int unsigned AW     = memories_address_width;

  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
  localparam logic [AW-1:0] WORDS_A   = AW'(WORDS);

  bank_e            read_bank_q, read_bank_d;
  logic [AW-1:0]    wr_count_q, wr_count_d;
  logic             vector_done_q, vector_done_d;
  logic [31:0]      vectors_committed_q, vectors_committed_d;
  logic             valid_q, valid_d;
  bank_e            rd_sel_q, rd_sel_d;
  logic             rd_zero_q, rd_zero_d;
  logic             write_en;

  logic [WORD_W-1:0] rdata0, rdata1;

  // Write pointer, commit and read-select next-state logic.
  always_comb begin
    read_bank_d         = read_bank_q;
    wr_count_d          = wr_count_q;
    vector_done_d       = 1'b0;
    vectors_committed_d = vectors_committed_q;
    valid_d             = valid_q;
    write_en            = 1'b0;
    rd_sel_d            = read_bank_q;
    rd_zero_d           = (rd_address >= WORDS_A);

    if (restart) begin
      wr_count_d = '0;
    end else if (wr_we) begin
      write_en = 1'b1;
      if (wr_count_q == LAST_WORD) begin
        wr_count_d          = '0;
        read_bank_d         = bank_e'(~read_bank_q);
        vector_done_d       = 1'b1;
        vectors_committed_d = vectors_committed_q + 32'd1;
        valid_d             = 1'b1;
      end else begin
        wr_count_d = wr_count_q + AW'(1);
      end
    end
  end

  // Control state registers; reset points the write bank at bank 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_bank_q         <= BANK_1;
      wr_count_q          <= '0;
      vector_done_q       <= 1'b0;
      vectors_committed_q <= '0;
      valid_q             <= 1'b0;
      rd_sel_q            <= BANK_0;
      rd_zero_q           <= 1'b1;
    end else begin
      read_bank_q         <= read_bank_d;
      wr_count_q          <= wr_count_d;
      vector_done_q       <= vector_done_d;
      vectors_committed_q <= vectors_committed_d;
      valid_q             <= valid_d;
      rd_sel_q            <= rd_sel_d;
      rd_zero_q           <= rd_zero_d;
    end
  end

  cg_vector_bank #(
    .DEPTH  (WORDS),
    .WIDTH  (WORD_W),
    .ADDR_W (AW)
  ) u_bank0 (
    .clk   (clk),
    .we    (write_en && (read_bank_q == BANK_1)),
    .waddr (wr_count_q),
    .wdata (wr_data),
    .raddr (rd_address),
    .rdata (rdata0)
  );

  cg_vector_bank #(
    .DEPTH  (WORDS),
    .WIDTH  (WORD_W),
    .ADDR_W (AW)
  ) u_bank1 (
    .clk   (clk),
    .we    (write_en && (read_bank_q == BANK_0)),
    .waddr (wr_count_q),
    .wdata (wr_data),
    .raddr (rd_address),
    .rdata (rdata1)
  );

  // The bank RAM outputs carry no reset, so the registered select and the
  // registered zero flag (set by reset or an out-of-range address) shape
  // rd_data after the RAM stage.
  always_comb begin
    rd_data = '0;
    if (!rd_zero_q) rd_data = (rd_sel_q == BANK_1) ? rdata1 : rdata0;
  end

  assign wr_count          = wr_count_q;
  assign read_bank         = read_bank_q;
  assign vector_done       = vector_done_q;
  assign vectors_committed = vectors_committed_q;
  assign valid             = valid_q;

endmodule

// File: doc/cg_vector_writeback.md
Name: cg_vector_writeback

Overview:
Write-back end of the CG ALU result path. It accepts the no_of_units-wide result chunks the ALU emits with its result write-enables (P, R or X update vectors) and assembles one full solution-length vector. The vector is stored in a ping-pong pair of banks, so readers always see the last complete vector while the next one is being written. One instance sits behind each ALU vector output. Its read port feeds the next iteration's memoryP_output, memoryR_output or memoryX_output path.

Parameters:
number_of_clusters, 40, clusters in the system
number_of_equations_per_cluster, 19, equations per cluster
element_width, 32, bits per element
no_of_units, 8, elements per write/read word
memories_address_width, 20, word address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
restart  in  1  synchronous; discard the partial vector and zero the write pointer
wr_we  in  1  write one result word this cycle
wr_data  in  no_of_units*element_width  result chunk; element 0 in the LSBs
wr_count  out  memories_address_width  next word index to be written
rd_address  in  memories_address_width  word index in the committed bank
rd_data  out  no_of_units*element_width  registered read data
read_bank  out  1  index of the committed (readable) bank
vector_done  out  1  one-cycle pulse after the last word of a vector commits
vectors_committed  out  32  count of completed vectors
valid  out  1  high once at least one vector has committed

Behaviour:
- WORDS = ceil(number_of_clusters*number_of_equations_per_cluster / no_of_units); 95 at the defaults. Word addresses run 0..WORDS-1.
- The write bank is always ~read_bank.
- Reset (async, immediate):
  - wr_count=0, read_bank=1 (so writes start in bank 0).
  - vector_done=0, vectors_committed=0, valid=0, rd_data=0.
  - Bank contents are not cleared.
- Write, on a rising edge with wr_we=1 and restart=0:
  - mem[~read_bank][wr_count] <= wr_data.
  - If wr_count==WORDS-1 (commit): wr_count<=0, read_bank toggles, vector_done<=1, vectors_committed increments, valid<=1.
  - Otherwise wr_count increments.
- vector_done is high for exactly the one cycle after the commit edge, then returns to 0.
- restart=1: wr_count<=0 and wr_we is ignored that cycle. read_bank, vectors_committed and valid are unchanged, and no vector_done pulse occurs.
- Read latency is 1 cycle: rd_data <= mem[read_bank][rd_address], using the read_bank value sampled before the edge.
  - A read on the commit edge returns the old committed bank.
  - A read on the next edge returns the new bank.
- rd_address >= WORDS: rd_data <= 0 and no wrap.
- Reads and writes never touch the same bank, so no collision handling is required.
- vectors_committed wraps from 2^32-1 to 0.
- Back-to-back wr_we (one word per cycle) is supported indefinitely, including back-to-back commits.
- Reset mid-vector: the partial vector is lost and writing restarts in bank 0 at word 0.

Decomposition:
- Shared package holds:
  - the WORDS derivation as a constant function of the cluster/equation/unit parameters;
  - the word-width constant no_of_units*element_width;
  - a clog2 helper for sizing internal pointers.
- One sub-module, cg_vector_bank, instantiated twice:
  - WORDS-deep, one synchronous write port, one synchronous registered read port;
  - inferable as block RAM;
  - top level muxes the two read outputs by the registered read_bank select.

Test Plan:
Use number_of_clusters=2, number_of_equations_per_cluster=3, no_of_units=2, element_width=32, giving WORDS=3.
1. Reset, then write words 0x11,0x22,0x33 on consecutive cycles.
   - wr_count steps 1,2,0.
   - vector_done pulses once, one cycle after the third write.
   - read_bank=0, vectors_committed=1, valid=1.
   - Reads of addresses 0..2 return 0x11,0x22,0x33 one cycle later.
2. After test 1, write 0xA1,0xA2 and read address 1 during those writes → reads return 0x22 (old bank).
   - Write 0xA3 while reading address 2 on that same edge → returns 0x33.
   - A read of address 2 on the next edge → returns 0xA3; read_bank=1.
3. Write two words, pulse restart with wr_we=1 in the same cycle.
   - wr_count=0, the wr_we that cycle is ignored, and there is no vector_done.
   - Three further writes commit: vectors_committed=1, and the data is exactly those three words.
4. Read rd_address=3 (out of range) → rd_data=0 the next cycle.
5. Assert reset asynchronously mid-vector (wr_count=2, between clock edges).
   - Outputs go to reset values immediately, without waiting for an edge.
   - Subsequent writes land in bank 0 starting at word 0.
6. Drive six consecutive writes with no gaps.
   - Two vector_done pulses arrive 3 cycles apart; vectors_committed=2.
   - read_bank goes 1→0→1.
